// File: rtl/diff_pkg.sv
// Shared constants and saturation helper for the signed integrator/comb family.
// Widths are passed as arguments so one package serves every sample width N.
package diff_pkg;

  typedef struct packed {
    logic [31:0] q;
    logic        ovf;
  } sat_t;

  // Largest positive N-bit value, 2^(n-1)-1, right-aligned in 32 bits.
  function automatic logic [31:0] mpos(input int unsigned n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  // Most negative N-bit value, -2^(n-1), sign-extended to 32 bits.
  function automatic logic [31:0] mneg(input int unsigned n);
    return ~mpos(n);
  endfunction

  // Clip an (n+1)-bit signed value (sign-extended into 33 bits) to n bits.
  function automatic sat_t sat_n(input logic [32:0] diff, input int unsigned n);
    sat_t r;
    r.q   = diff[31:0];
    r.ovf = 1'b0;
    // The two top bits of an (n+1)-bit result disagree only when it falls outside n bits.
    if (diff[n] != diff[n-1]) begin
      r.ovf = 1'b1;
      r.q   = diff[n] ? mneg(n) : mpos(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/sdelay_line.sv
// M-deep, N-wide sample history with enable and synchronous active-low clear.
// tap is the oldest stored sample (accepted M samples ago).
module sdelay_line #(
  parameter int N = 16,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] tap
);

  logic [N-1:0] hist_reg [M];

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < M; k++) hist_reg[k] <= '0;
    end else if (en) begin
      hist_reg[0] <= d;
      for (int k = 1; k < M; k++) hist_reg[k] <= hist_reg[k-1];
    end
  end

  assign tap = hist_reg[M-1];

endmodule

// File: rtl/diff_signed.sv
// Signed first-difference (comb) stage: Q = D - D[M accepted samples ago],
// saturating or wrapping, one-cycle registered latency.
module diff_signed
  import diff_pkg::*;
#(
  parameter int N   = 16,
  parameter int M   = 1,
  parameter int SAT = 1
) (
  input  logic         C,
  input  logic         CLR,
  input  logic         V_IN,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         V_OUT,
  output logic         OVF,
  output logic         PRIMED
);

  localparam int CW = $clog2(M + 1);

  logic [N-1:0]  oldest;
  logic [N:0]    diff;
  logic [32:0]   diff_ext;
  sat_t          sat;
  logic [N-1:0]  q_next;
  logic          ovf_next;
  logic [CW-1:0] fill_reg;
  logic          unused_sat;

  // Gaps (V_IN=0) do not shift the history, so idle cycles never age it.
  sdelay_line #(.N(N), .M(M)) u_hist (
    .clk (C),
    .clr (CLR),
    .en  (V_IN),
    .d   (D),
    .tap (oldest)
  );

  always_comb begin
    diff     = {D[N-1], D} - {oldest[N-1], oldest};
    diff_ext = 33'(signed'(diff));
    sat      = sat_n(diff_ext, N);
    q_next   = diff[N-1:0];
    ovf_next = 1'b0;
    if (SAT != 0) begin
      q_next   = sat.q[N-1:0];
      ovf_next = sat.ovf;
    end
  end

  assign unused_sat = ^{sat.q, diff_ext};

  always_ff @(posedge C) begin
    if (!CLR) begin
      Q        <= '0;
      V_OUT    <= 1'b0;
      OVF      <= 1'b0;
      fill_reg <= '0;
    end else begin
      V_OUT <= V_IN;
      if (V_IN) begin
        Q   <= q_next;
        OVF <= ovf_next;
        if (fill_reg != CW'(M)) fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  assign PRIMED = (fill_reg == CW'(M));

endmodule

// File: tb/tb_diff_signed.sv
// Bench for diff_signed: four instances (M/SAT variants) driven one at a time,
// expected results queued at issue and checked by an independent monitor.
module tb_diff_signed;

  localparam int NI = 4;
  localparam int MS [NI] = '{1, 4, 1, 2};
  localparam int SS [NI] = '{1, 1, 0, 1};

  typedef struct {
    int          idx;
    logic [15:0] q;
    logic        ovf;
    logic        primed;
  } exp_t;

  logic        clk = 1'b0;
  logic [NI-1:0] clr_s;
  logic [NI-1:0] v_in_s;
  logic [15:0] d_s [NI];
  logic [15:0] q_s [NI];
  logic [NI-1:0] v_out_s;
  logic [NI-1:0] ovf_s;
  logic [NI-1:0] primed_s;

  exp_t sb[$];
  int   cnt [NI];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    diff_signed #(.N(16), .M(MS[gi]), .SAT(SS[gi])) u_dut (
      .C      (clk),
      .CLR    (clr_s[gi]),
      .V_IN   (v_in_s[gi]),
      .D      (d_s[gi]),
      .Q      (q_s[gi]),
      .V_OUT  (v_out_s[gi]),
      .OVF    (ovf_s[gi]),
      .PRIMED (primed_s[gi])
    );
  end

  // Monitor: every presented output must match the oldest queued expectation,
  // and every expectation must be met exactly one edge after issue.
  always @(posedge clk) begin
    exp_t e;
    #2;
    for (int i = 0; i < NI; i++) begin
      if (v_out_s[i]) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_vout inst=%0d q=%0d", i, $signed(q_s[i]));
        end else begin
          e = sb.pop_front();
          if (e.idx != i || q_s[i] !== e.q || ovf_s[i] !== e.ovf || primed_s[i] !== e.primed) begin
            bad++;
            $display("FAIL sample inst=%0d got q=%0d ovf=%0b primed=%0b, want inst=%0d q=%0d ovf=%0b primed=%0b",
                     i, $signed(q_s[i]), ovf_s[i], primed_s[i], e.idx, $signed(e.q), e.ovf, e.primed);
          end else begin
            $display("ok   inst=%0d q=%0d ovf=%0b primed=%0b", i, $signed(q_s[i]), ovf_s[i], primed_s[i]);
          end
        end
      end
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_vout inst=%0d got none, want q=%0d", e.idx, $signed(e.q));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic send(input int i, input int dv, input int eq, input logic eo);
    exp_t e;
    @(negedge clk);
    clr_s[i]  = 1'b1;
    v_in_s[i] = 1'b1;
    d_s[i]    = 16'(dv);
    if (cnt[i] < MS[i]) cnt[i]++;
    e.idx    = i;
    e.q      = 16'(eq);
    e.ovf    = eo;
    e.primed = (cnt[i] == MS[i]);
    sb.push_back(e);
  endtask

  task automatic idle(input int i, input int dv);
    @(negedge clk);
    clr_s[i]  = 1'b1;
    v_in_s[i] = 1'b0;
    d_s[i]    = 16'(dv);
  endtask

  task automatic pulse_reset(input int i, input logic vin, input int dv);
    @(negedge clk);
    clr_s[i]  = 1'b0;
    v_in_s[i] = vin;
    d_s[i]    = 16'(dv);
    cnt[i]    = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr_s  = '0;
    v_in_s = '0;
    for (int i = 0; i < NI; i++) begin
      d_s[i] = '0;
      cnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    clr_s = '1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_q%0d", i), 32'(q_s[i]), 32'd0);
      chk($sformatf("reset_flags%0d", i), {29'd0, v_out_s[i], ovf_s[i], primed_s[i]}, 32'd0);
    end

    // Ramp, M=1 SAT=1
    send(0, 0, 0, 0);
    send(0, 400, 400, 0);
    send(0, 800, 400, 0);
    send(0, 1200, 400, 0);
    send(0, 1200, 0, 0);
    send(0, 800, -400, 0);
    idle(0, 0);

    // Saturation, M=1 SAT=1
    pulse_reset(0, 1'b0, 0);
    send(0, -32768, -32768, 0);
    send(0, 32767, 32767, 1);
    send(0, 32767, 0, 0);
    send(0, -32768, -32768, 1);
    idle(0, 0);

    // Delay M=4
    send(1, 10, 10, 0);
    send(1, 20, 20, 0);
    send(1, 30, 30, 0);
    send(1, 40, 40, 0);
    send(1, 50, 40, 0);
    send(1, 60, 40, 0);
    idle(1, 0);

    // Wrap, M=1 SAT=0
    send(2, 32767, 32767, 0);
    send(2, -32768, 1, 0);
    send(2, -32768, 0, 0);
    send(2, 32767, -1, 0);
    idle(2, 0);

    // Gapped input on the wrapping instance
    pulse_reset(2, 1'b0, 0);
    send(2, 100, 100, 0);
    for (int g = 0; g < 3; g++) begin
      idle(2, 999);
      @(posedge clk); #1;
      chk($sformatf("gap_hold_q%0d", g), 32'(q_s[2]), 32'd100);
    end
    send(2, 150, 50, 0);
    idle(2, 0);

    // Mid-stream reset, M=2
    send(3, 10, 10, 0);
    send(3, 20, 20, 0);
    send(3, 30, 20, 0);
    pulse_reset(3, 1'b1, 500);
    @(posedge clk); #1;
    chk("midreset_q", 32'(q_s[3]), 32'd0);
    chk("midreset_flags", {29'd0, v_out_s[3], ovf_s[3], primed_s[3]}, 32'd0);
    send(3, 700, 700, 0);
    idle(3, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diff_signed.md
# diff_signed

Signed first-difference (comb) stage: the inverse of the `accum_signed` integrator. Each accepted sample produces Q = D − D(delayed by M accepted samples), either saturating or two's-complement wrapping. It recovers the per-cycle increment stream from an accumulator's running-sum output, and serves as the comb half of integrator/comb filter chains in the learn area.

## Interface

- N, 16: sample width, signed two's complement, 4..32
- M, 1: differential delay in accepted samples, 1..16
- SAT, 1: 1 = saturate result to [−2^(N−1), 2^(N−1)−1]; 0 = wrap modulo 2^N (exact inverse of a wrapping accumulator)

- C  input  1  clock, rising-edge active
- CLR  input  1  reset, synchronous, active-low; sampled on rising C
- V_IN  input  1  D valid; sample accepted on a rising C with V_IN=1
- D  input  N  signed input sample (accumulator output)
- Q  output  N  signed difference, registered
- V_OUT  output  1  Q valid strobe, one cycle per accepted sample
- OVF  output  1  result of the sample now on Q was saturated (SAT=1 only; tied 0 when SAT=0)
- PRIMED  output  1  high once M samples have been accepted since reset

## Operation

- Reset (CLR=0 at a rising C): Q=0, V_OUT=0, OVF=0, PRIMED=0, all M history entries=0, fill counter=0. CLR overrides V_IN.
- Accept (CLR=1, V_IN=1): diff = D − hist[M−1], computed at N+1 bits with sign extension.
  - SAT=1: diff > 2^(N−1)−1 → Q=2^(N−1)−1, OVF=1; diff < −2^(N−1) → Q=−2^(N−1), OVF=1; otherwise Q=diff[N−1:0], OVF=0.
  - SAT=0: Q=diff[N−1:0], OVF=0.
  - History shifts: hist[0]←D, hist[k]←hist[k−1].
  - Fill counter increments, saturating at M; PRIMED=1 when counter = M.
  - V_OUT=1.
- Idle (CLR=1, V_IN=0): Q, OVF, history, and counter hold; V_OUT=0.
- Before PRIMED, history is zero, so Q = D. This is exact when the upstream accumulator is also reset to 0.
- Wrap-around: with SAT=0 and a wrapping accumulator upstream, Q equals the accumulator's input exactly, including across overflow. With SAT=1 and a saturating accumulator upstream, Q is the clipped increment.

## Timing

- Latency is 1 cycle: a sample accepted at edge k appears on Q/V_OUT/OVF after edge k; PRIMED updates on the same edge.
- Throughput is one sample per cycle; there is no backpressure.
- V_IN may toggle every cycle, and gaps do not age the history.
- Reset mid-stream: the in-flight sample is discarded, and on the next cycle V_OUT=0 and all state is zero.
- CLR=0 together with V_IN=1: reset wins, and the sample is not recorded.
- Outputs depend only on registers; there is no combinational path from D/V_IN to any output.

## Structure

- Package `diff_pkg`:
  - N-parameterised constants MPOS = 2^(N−1)−1 and MNEG = −2^(N−1). These are shared with `accum_signed` benches.
  - Function `sat_n`, which clips an N+1-bit value to N bits and returns an overflow flag.
- One sub-module, `sdelay_line`:
  - Purpose: M-deep, N-wide shift register with enable and synchronous active-low clear, exposing the oldest tap.
  - Top level holds the subtractor, saturation, fill counter, and output registers.

## Test plan

- Reset then ramp (N=16, M=1, SAT=1): V_IN=1 continuously, D = 0, 400, 800, 1200, 1200, 800 → Q = 0, 400, 400, 400, 0, −400; V_OUT=1 each cycle; PRIMED=1 after the first accepted sample.
- Delay M=4: D = 10, 20, 30, 40, 50, 60 → Q = 10, 20, 30, 40, 40, 40; PRIMED rises after the 4th sample.
- Saturation (SAT=1): D=−32768 then D=32767 → second Q=32767 with OVF=1. D=32767 then D=−32768 → Q=−32768 with OVF=1.
- Wrap (SAT=0): D=32767 then D=−32768 → Q=1, OVF=0. D=−32768 then 32767 → Q=−1.
- Gapped input: D=100 (V_IN=1), then three cycles with V_IN=0 and D=999, then D=150 (V_IN=1) → Q holds 100 with V_OUT=0 during the gap, then Q=50.
- Mid-stream reset (M=2): after 3 samples, CLR=0 for one cycle with V_IN=1 and D=500 → Q=0, V_OUT=0, PRIMED=0. The next sample D=700 gives Q=700.
